// File: rtl/cpu_ctrl_pkg.sv
// Shared control-path types for the 5-stage MIPS core.
// Latency: n/a (types and constants only). Backpressure: n/a.
// Contents: ALU op encodings, the decoder control bundle, the bubble constant
// and the per-stage register layouts used downstream of ID/EX.
package cpu_ctrl_pkg;

  // ALU operation encodings as produced by the decoder.
  localparam logic [1:0] ALU_OP_ADD    = 2'd0;
  localparam logic [1:0] ALU_OP_SUB    = 2'd1;
  localparam logic [1:0] ALU_OP_R_TYPE = 2'd2;

  // Decoder control bundle. alu_op is one two-bit field, so the bundle has
  // nine fields in ten bits.
  typedef struct packed {
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       branch;
    logic       mem_read;
    logic       mem_2_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic       jump;
  } ctrl_bundle_t;

  // A bubble clears every control bit, so it can never write memory or the
  // register file.
  localparam ctrl_bundle_t CTRL_BUBBLE = '{alu_op: ALU_OP_ADD, default: 1'b0};

  // Controls still needed once an instruction has left EX.
  typedef struct packed {
    logic valid;
    logic branch;
    logic mem_read;
    logic mem_write;
    logic mem_2_reg;
    logic reg_write;
  } ex_mem_t;

  // Controls still needed in WB.
  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_2_reg;
  } mem_wb_t;

  // A jump redirects fetch from ID and has no architectural write of its
  // own, so its write enables are cleared before it enters the pipeline.
  function automatic ctrl_bundle_t strip_writes(ctrl_bundle_t b);
    ctrl_bundle_t r;
    r           = b;
    r.reg_write = 1'b0;
    r.mem_write = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/hazard_detect_unit.sv
// Load-use hazard detector: a load in EX whose rt feeds the instruction in ID.
// Latency: purely combinational. Backpressure: none; the result drives stall.
// Ports: ex_valid_i/ex_mem_read_i/ex_rt_i describe the EX instruction,
//        id_valid_i/id_rs_i/id_rt_i the ID instruction; hazard_o flags the stall.
module hazard_detect_unit #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  ex_valid_i,
  input  logic                  ex_mem_read_i,
  input  logic [REG_ADDR_W-1:0] ex_rt_i,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs_i,
  input  logic [REG_ADDR_W-1:0] id_rt_i,
  output logic                  hazard_o
);

  logic ex_rt_nonzero;
  logic src_match;

  // $zero never carries a dependency.
  assign ex_rt_nonzero = (ex_rt_i != '0);
  // rt is compared even for I-type consumers that do not read it; a
  // spurious one-cycle stall is cheaper than decoding which fields are read.
  assign src_match     = (ex_rt_i == id_rs_i) | (ex_rt_i == id_rt_i);

  assign hazard_o = ex_valid_i & ex_mem_read_i & ex_rt_nonzero & id_valid_i & src_match;

endmodule

// File: rtl/control_pipeline.sv
// Carries decoder controls through ID/EX, EX/MEM and MEM/WB; handles load-use
// stalls and wrong-path squash on a taken branch or jump.
// Latency: one cycle per stage. Backpressure: stall holds PC and IF/ID upstream.
// Ports: id_* decoder bundle and source regs in; mem_zero from EX/MEM;
//        stall/flush_if_id/pc_src combinational; ex_*/mem_*/wb_* registered.
module control_pipeline
  import cpu_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [1:0]            id_alu_op,
  input  logic                  id_reg_dst,
  input  logic                  id_branch,
  input  logic                  id_mem_read,
  input  logic                  id_mem_2_reg,
  input  logic                  id_mem_write,
  input  logic                  id_alu_src,
  input  logic                  id_reg_write,
  input  logic                  id_jump,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  mem_zero,
  output logic                  stall,
  output logic                  flush_if_id,
  output logic                  pc_src,
  output logic                  ex_valid,
  output logic                  ex_reg_dst,
  output logic                  ex_alu_src,
  output logic [1:0]            ex_alu_op,
  output logic [REG_ADDR_W-1:0] ex_rt,
  output logic                  mem_valid,
  output logic                  mem_branch,
  output logic                  mem_mem_read,
  output logic                  mem_mem_write,
  output logic                  wb_valid,
  output logic                  wb_reg_write,
  output logic                  wb_mem_2_reg
);

  ctrl_bundle_t id_ctrl;

  logic                  id_ex_valid_q, id_ex_valid_d;
  ctrl_bundle_t          id_ex_ctrl_q,  id_ex_ctrl_d;
  logic [REG_ADDR_W-1:0] id_ex_rt_q,    id_ex_rt_d;
  ex_mem_t               ex_mem_q,      ex_mem_d;
  mem_wb_t               mem_wb_q,      mem_wb_d;

  logic hazard;
  logic taken;
  logic ex_jump_unused;

  assign id_ctrl = '{
    alu_op:    id_alu_op,
    reg_dst:   id_reg_dst,
    branch:    id_branch,
    mem_read:  id_mem_read,
    mem_2_reg: id_mem_2_reg,
    mem_write: id_mem_write,
    alu_src:   id_alu_src,
    reg_write: id_reg_write,
    jump:      id_jump
  };

  hazard_detect_unit #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_hazard (
    .ex_valid_i    (id_ex_valid_q),
    .ex_mem_read_i (id_ex_ctrl_q.mem_read),
    .ex_rt_i       (id_ex_rt_q),
    .id_valid_i    (id_valid),
    .id_rs_i       (id_rs),
    .id_rt_i       (id_rt),
    .hazard_o      (hazard)
  );

  // Branch resolves in MEM; the zero flag arrives alongside the EX/MEM register.
  assign taken = ex_mem_q.valid & ex_mem_q.branch & mem_zero;

  // Redirects are suppressed during reset so nothing upstream moves while the
  // pipeline is being cleared. A taken branch overrides the load-use stall:
  // the dependent instruction is on the wrong path and is flushed instead.
  assign pc_src      = ~rst & taken;
  assign stall       = ~rst & hazard & ~taken;
  assign flush_if_id = ~rst & (taken | (id_valid & id_jump & ~hazard));

  always_comb begin
    id_ex_valid_d = 1'b0;
    id_ex_ctrl_d  = CTRL_BUBBLE;
    id_ex_rt_d    = '0;
    // ID/EX takes a bubble when squashed, when stalled, or when ID is empty.
    if (!taken && !hazard && id_valid) begin
      id_ex_valid_d = 1'b1;
      id_ex_ctrl_d  = id_jump ? strip_writes(id_ctrl) : id_ctrl;
      id_ex_rt_d    = id_rt;
    end

    ex_mem_d = '0;
    // The instruction in EX is younger than the taken branch, so it dies too.
    if (!taken) begin
      ex_mem_d = '{
        valid:     id_ex_valid_q,
        branch:    id_ex_ctrl_q.branch,
        mem_read:  id_ex_ctrl_q.mem_read,
        mem_write: id_ex_ctrl_q.mem_write,
        mem_2_reg: id_ex_ctrl_q.mem_2_reg,
        reg_write: id_ex_ctrl_q.reg_write
      };
    end

    // The branch itself is architecturally complete and always retires.
    mem_wb_d = '{
      valid:     ex_mem_q.valid,
      reg_write: ex_mem_q.reg_write,
      mem_2_reg: ex_mem_q.mem_2_reg
    };
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_ex_valid_q <= 1'b0;
      id_ex_ctrl_q  <= CTRL_BUBBLE;
      id_ex_rt_q    <= '0;
      ex_mem_q      <= '0;
      mem_wb_q      <= '0;
    end else begin
      id_ex_valid_q <= id_ex_valid_d;
      id_ex_ctrl_q  <= id_ex_ctrl_d;
      id_ex_rt_q    <= id_ex_rt_d;
      ex_mem_q      <= ex_mem_d;
      mem_wb_q      <= mem_wb_d;
    end
  end

  // The jump bit has no consumer past ID; it rides along so ID/EX holds the
  // complete decoder bundle.
  assign ex_jump_unused = id_ex_ctrl_q.jump;

  assign ex_valid      = id_ex_valid_q;
  assign ex_reg_dst    = id_ex_ctrl_q.reg_dst;
  assign ex_alu_src    = id_ex_ctrl_q.alu_src;
  assign ex_alu_op     = id_ex_ctrl_q.alu_op;
  assign ex_rt         = id_ex_rt_q;
  assign mem_valid     = ex_mem_q.valid;
  assign mem_branch    = ex_mem_q.branch;
  assign mem_mem_read  = ex_mem_q.mem_read;
  assign mem_mem_write = ex_mem_q.mem_write;
  assign wb_valid      = mem_wb_q.valid;
  assign wb_reg_write  = mem_wb_q.reg_write;
  assign wb_mem_2_reg  = mem_wb_q.mem_2_reg;

endmodule
